pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB).
//  Detects load-use hazards and holds the pipe for multi-cycle divides.
//  Flushes younger stages on a taken branch/jump resolved in MEM, and drains the pipe on exception/eret.
//  Outputs feed the write-enable and flush inputs of every pipeline register plus the PC register.
// PARAMETERS
//  DIV_CYCLES    32  EX-stage occupancy of div/divu in cycles (legal range 2..255)
//  CNT_W         8   width of divide counter; must satisfy 2**CNT_W > DIV_CYCLES
// PORTS
//  clock          in   1   rising-edge clock
//  reset          in   1   synchronous, active-high
//  id_rs          in   5   rs field of instruction in ID
//  id_rt          in   5   rt field of instruction in ID
//  id_uses_rt     in   1   ID instruction reads rt as a source
//  ex_memread     in   1   EX instruction is a load (MemRead | IORead)
//  ex_waddr       in   5   destination register of EX instruction
//  ex_div_start   in   1   div/divu present in EX this cycle (first EX cycle)
//  mem_redirect   in   1   taken branch / jump / jr / jalr resolved in MEM
//  exception      in   1   exception or interrupt accepted (overflow, div0, syscall, break, RI, irq)
//  eret           in   1   eret committing
//  pc_write       out  1   PC register update enable
//  if_id_write    out  1   IF_ID hold when 0
//  id_ex_write    out  1   ID_EX hold when 0
//  if_id_flush    out  1   IF_ID loads bubble
//  id_ex_flush    out  1   ID_EX loads bubble
//  ex_mem_flush   out  1   EX_MEM loads bubble
//  mem_wb_flush   out  1   MEM_WB loads bubble
//  div_busy       out  1   divide occupying EX
//  state          out  2   FSM state: 0 RUN, 1 DIV_WAIT, 2 EXC_FLUSH
// BEHAVIOUR
//  - While reset=1: state=RUN, counter=0, div_busy=0, pc_write=0, if_id_write=0, id_ex_write=0.
//    All four *_flush outputs =1 while reset=1. First cycle after reset: RUN with all writes=1, flushes=0.
//  - Outputs are combinational from registered state/counter plus current inputs (0-cycle latency).
//  - Priority per cycle: exception|eret > mem_redirect > divide stall > load-use.
//  - Load-use, RUN only: triggered by ex_memread & ex_waddr!=0 & (ex_waddr==id_rs | id_uses_rt & ex_waddr==id_rt).
//    Response: pc_write=0, if_id_write=0, id_ex_flush=1 for exactly one cycle. A $0 destination never stalls.
//  - RUN + ex_div_start: counter<=DIV_CYCLES-1, next state DIV_WAIT.
//    Cycle of entry: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_flush=1.
//  - DIV_WAIT: same hold/bubble outputs; counter decrements each cycle. div_busy=1 in DIV_WAIT and the entry cycle.
//    When counter==1 at clock edge -> RUN; the divide then leaves EX on the next edge.
//    Total EX occupancy is exactly DIV_CYCLES cycles.
//  - ex_div_start is ignored in DIV_WAIT, so a held divide never re-triggers.
//  - mem_redirect: if_id_flush=id_ex_flush=ex_mem_flush=1, pc_write=1 for one cycle.
//    If in DIV_WAIT, the divide is younger, so it is aborted: counter<=0, state<=RUN.
//    This overrides load-use in the same cycle.
//  - exception|eret (any state): all four flushes=1, pc_write=1, counter<=0, next state EXC_FLUSH.
//    EXC_FLUSH lasts one cycle: if_id/id_ex/ex_mem flush=1, pc_write=1, mem_wb_flush=0; then RUN.
//    An exception during EXC_FLUSH restarts EXC_FLUSH.
//  - Simultaneous load-use and ex_div_start is impossible (single EX instruction); divide takes precedence.
//  - Illegal state 3 -> RUN on next edge, outputs as RUN.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds outputs stall_cycles[31:0], flush_events[31:0].
//    stall_cycles counts cycles with pc_write=0 outside reset.
//    flush_events counts cycles with id_ex_flush=1 caused by redirect/exception.
//    Both counters clear on reset and saturate at 32'hFFFFFFFF.
//  HAZARD_STATS_EN undefined: ports and counters absent; core behaviour identical.
// TESTING
//  1 lw $5 in EX (ex_waddr=5), ID reads rs=5 -> one cycle pc_write=0, if_id_write=0, id_ex_flush=1, then normal.
//  2 ex_waddr=0 with ex_memread=1, id_rs=0 -> no stall.
//    Also id_rt=5 with id_uses_rt=0 -> no stall.
//  3 DIV_CYCLES=4, ex_div_start pulse -> id_ex_write=0 and div_busy=1 for exactly 4 cycles, state 1 for 3, then RUN.
//  4 mem_redirect during DIV_WAIT (cycle 2) -> 3 flushes=1, pc_write=1, state=RUN next cycle, div_busy=0.
//  5 exception with mem_redirect same cycle -> all 4 flushes=1; next cycle state=2, mem_wb_flush=0; then RUN.
//  6 reset asserted mid-DIV_WAIT -> all flushes=1, writes=0 immediately; after release state=0, counter=0.
//    HAZARD_STATS_EN build also clears counters to 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline registers and the PC.
// Handles load-use stalls, multi-cycle divide holds, MEM-stage redirects and
// exception/eret drains.
// Optional feature: define HAZARD_STATS_EN to add the stall_cycles and
// flush_events statistics counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_waddr,
    input  logic        ex_div_start,
    input  logic        mem_redirect,
    input  logic        exception,
    input  logic        eret,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic        div_busy,
`ifdef HAZARD_STATS_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events,
`endif
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DIV_WAIT  = 2'd1,
        EXC_FLUSH = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_load_use;

    // Load in EX writes a register the ID instruction reads; $0 never hazards.
    assign w_load_use = ex_memread && (ex_waddr != 5'd0) &&
                        ((ex_waddr == id_rs) || (id_uses_rt && (ex_waddr == id_rt)));

    // State and divide counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next state and pipeline control, prioritised exception > redirect > divide > load-use.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        div_busy     = 1'b0;
        state        = r_state;

        if (reset) begin
            w_next_state = RUN;
            w_next_cnt   = '0;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
            state        = RUN;
        end else if (exception || eret) begin
            w_next_state = EXC_FLUSH;
            w_next_cnt   = '0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (mem_redirect) begin
            // A divide in EX is younger than the redirecting branch, so it is dropped.
            w_next_state = RUN;
            w_next_cnt   = '0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (ex_div_start) begin
                        w_next_state = DIV_WAIT;
                        w_next_cnt   = CNT_W'(DIV_CYCLES - 1);
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_flush = 1'b1;
                        div_busy     = 1'b1;
                    end else if (w_load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_flush  = 1'b1;
                    end
                end
                DIV_WAIT: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_flush = 1'b1;
                    div_busy     = 1'b1;
                    w_next_cnt   = r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        w_next_state = RUN;
                        w_next_cnt   = '0;
                    end
                end
                EXC_FLUSH: begin
                    w_next_state = RUN;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                end
                default: begin
                    w_next_state = RUN;
                    w_next_cnt   = '0;
                    state        = RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;
    logic        w_evt_flush;

    // id_ex_flush not caused by a load-use stall comes from a redirect or exception drain.
    assign w_evt_flush = id_ex_flush && (exception || eret || mem_redirect || (r_state == EXC_FLUSH));

    // Saturating statistics counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!pc_write && (r_stall_cycles != 32'hFFFF_FFFF))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_evt_flush && (r_flush_events != 32'hFFFF_FFFF))
                r_flush_events <= r_flush_events + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule
